// File: rtl/shifter_ctrl_pkg.sv
// Shared encodings, request/load records and the LOAD-time resolution
// function for the shifter operand sequencer.
package shifter_ctrl_pkg;

  // Operand mux select encodings
  localparam logic [1:0] SEL_ROT_IMM   = 2'b00;
  localparam logic [1:0] SEL_SHIFT_IMM = 2'b01;
  localparam logic [1:0] SEL_REG_SHIFT = 2'b10;
  localparam logic [1:0] SEL_ILLEGAL   = 2'b11;

  // Shift type encodings
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Remaining-count width: holds 0..33
  localparam int         REM_W   = 6;
  localparam logic [5:0] REM_MAX = 6'd33;

  // Request fields captured at the accept edge
  typedef struct packed {
    logic [1:0]  sel;
    logic [1:0]  shift_type;
    logic [7:0]  imm8;
    logic [3:0]  rotate_imm;
    logic [4:0]  shift_imm;
    logic [31:0] rm;
    logic [7:0]  rs_lo;
    logic        carry_in;
  } req_t;

  // Working state produced by LOAD
  typedef struct packed {
    logic [31:0]      value;
    logic [1:0]       shift_type;
    logic [REM_W-1:0] rem;
    logic             carry;
    logic             err;
  } load_t;

  // Resolve the shift amount and every zero-amount special case up front so
  // that the serial engine only ever sees a plain shift of rem bits.
  function automatic load_t resolve_req(input req_t r);
    load_t l;
    l.value      = r.rm;
    l.shift_type = r.shift_type;
    l.rem        = '0;
    l.carry      = r.carry_in;
    l.err        = 1'b0;
    case (r.sel)
      SEL_ROT_IMM: begin
        l.value      = {24'h0, r.imm8};
        l.shift_type = SH_ROR;
        l.rem        = {1'b0, r.rotate_imm, 1'b0};
      end
      SEL_SHIFT_IMM: begin
        l.rem = {1'b0, r.shift_imm};
        if (r.shift_imm == 5'd0) begin
          case (r.shift_type)
            SH_LSL:         l.rem = '0;
            SH_LSR, SH_ASR: l.rem = 6'd32;
            default: begin
              // RRX: one-bit rotate through carry, done here in one go
              l.value = {r.carry_in, r.rm[31:1]};
              l.carry = r.rm[0];
              l.rem   = '0;
            end
          endcase
        end
      end
      SEL_REG_SHIFT: begin
        if (r.rs_lo == 8'd0) begin
          l.rem = '0;
        end else if (r.shift_type == SH_ROR) begin
          if (r.rs_lo[4:0] == 5'd0) begin
            l.carry = r.rm[31];
            l.rem   = '0;
          end else begin
            l.rem = {1'b0, r.rs_lo[4:0]};
          end
        end else begin
          // Anything past 33 behaves exactly like 33
          l.rem = (r.rs_lo > 8'(REM_MAX)) ? REM_MAX : r.rs_lo[REM_W-1:0];
        end
      end
      default: begin
        l.value = '0;
        l.err   = 1'b1;
        l.rem   = '0;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/shifter_ctrl_shift_step.sv
// One serial shift step: shifts value by k (1..32) bits and reports the last
// bit shifted out. k == 0 passes value and carry through unchanged.
module shift_step
  import shifter_ctrl_pkg::*;
(
  input  logic [31:0] value_i,
  input  logic [1:0]  shift_type_i,
  input  logic [5:0]  k_i,
  input  logic        carry_i,
  output logic [31:0] value_o,
  output logic        carry_o
);

  logic [32:0]        lsl_t;
  logic [32:0]        lsr_t;
  logic signed [32:0] asr_t;
  logic [31:0]        ror_v;

  // Extend by one bit so the last bit shifted out lands in a fixed position
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lsl_t   = {1'b0, value_i} << k_i;
    lsr_t   = {value_i, 1'b0} >> k_i;
    asr_t   = $signed({value_i, 1'b0}) >>> k_i;
    ror_v   = (value_i >> k_i) | (value_i << (6'd32 - k_i));
    value_o = value_i;
    carry_o = carry_i;
    if (k_i != 6'd0) begin
      case (shift_type_i)
        SH_LSL: begin
          value_o = lsl_t[31:0];
          carry_o = lsl_t[32];
        end
        SH_LSR: begin
          value_o = lsr_t[32:1];
          carry_o = lsr_t[0];
        end
        SH_ASR: begin
          value_o = asr_t[32:1];
          carry_o = asr_t[0];
        end
        default: begin
          value_o = ror_v;
          carry_o = ror_v[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_ctrl.sv
// Multi-cycle sequencer producing the ARM data-processing operand2 and its
// shifter carry-out, shifting STEP bits per cycle between decode and ALU.
module shifter_ctrl
  import shifter_ctrl_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  sel,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rotate_imm,
  input  logic [4:0]  shift_imm,
  input  logic [31:0] rm,
  input  logic [31:0] rs,
  input  logic        carry_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] shifter_operand,
  output logic        shifter_carry,
  output logic        res_err,
  output logic        busy
);

  localparam logic [REM_W-1:0] STEP_K = REM_W'(STEP);

  logic [1:0]       state_q, state_d;
  req_t             req_q, req_d;
  logic [31:0]      val_q, val_d;
  logic [1:0]       type_q, type_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [31:0]      op_q, op_d;
  logic             op_carry_q, op_carry_d;
  logic             res_err_q, res_err_d;
  logic             res_valid_q, res_valid_d;

  load_t            ld;
  logic [REM_W-1:0] step_k;
  logic [31:0]      step_value;
  logic             step_carry;

  // Only rs[7:0] takes part in register-specified shifts
  logic             unused_rs_hi;
  assign unused_rs_hi = ^rs[31:8];

  assign ld     = resolve_req(req_q);
  assign step_k = (rem_q > STEP_K) ? STEP_K : rem_q;

  shift_step u_shift_step (
    .value_i      (val_q),
    .shift_type_i (type_q),
    .k_i          (step_k),
    .carry_i      (carry_q),
    .value_o      (step_value),
    .carry_o      (step_carry)
  );

  // Next-state: capture at accept, resolve in LOAD, shift serially, publish in DONE
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    val_d       = val_q;
    type_d      = type_q;
    rem_d       = rem_q;
    carry_d     = carry_q;
    err_d       = err_q;
    op_d        = op_q;
    op_carry_d  = op_carry_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.sel        = sel;
          req_d.shift_type = shift_type;
          req_d.imm8       = imm8;
          req_d.rotate_imm = rotate_imm;
          req_d.shift_imm  = shift_imm;
          req_d.rm         = rm;
          req_d.rs_lo      = rs[7:0];
          req_d.carry_in   = carry_in;
          state_d          = ST_LOAD;
        end
      end
      ST_LOAD: begin
        val_d   = ld.value;
        type_d  = ld.shift_type;
        rem_d   = ld.rem;
        carry_d = ld.carry;
        err_d   = ld.err;
        state_d = (ld.rem == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        val_d   = step_value;
        carry_d = step_carry;
        rem_d   = rem_q - step_k;
        if (rem_q <= STEP_K) state_d = ST_DONE;
      end
      default: begin
        // First DONE cycle moves the result into the output registers;
        // they then hold until the consumer takes it.
        if (!res_valid_q) begin
          op_d        = val_q;
          op_carry_d  = carry_q;
          res_err_d   = err_q;
          res_valid_d = 1'b1;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  // Control and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      op_carry_q  <= 1'b0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      op_carry_q  <= op_carry_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Datapath registers; always written before being read, so left unreset
  always_ff @(posedge clk) begin
    // NOTE: no reset here on purpose; the FSM guarantees a write precedes any use.
    req_q   <= req_d;
    val_q   <= val_d;
    type_q  <= type_d;
    rem_q   <= rem_d;
    carry_q <= carry_d;
    err_q   <= err_d;
  end

  assign req_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign res_valid       = res_valid_q;
  assign shifter_operand = op_q;
  assign shifter_carry   = op_carry_q;
  assign res_err         = res_err_q;

endmodule
